ahb_sram_slave: RTL and testbench

//  AHB-Lite slave backed by a word-organised register-file SRAM.
//  It is the responder on the AHB master port of the AXI-to-AHB bridge and

---
 rtl/ahb_sram_slave.sv | 208 ++++++++++++++++++++
 tb/tb_ahb_sram_slave.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave fronting a word-organised register-file SRAM.
// Programmable wait states, byte-lane writes, two-cycle ERROR responses, and
// write-to-read forwarding so back-to-back beats run at one beat per cycle.
module ahb_sram_slave #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 64,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);

    localparam int unsigned NumBytes = DATA_WIDTH / 8;
    localparam int unsigned LaneW    = $clog2(NumBytes);
    localparam int unsigned IdxW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // Elaboration-time guards on the supported configuration space.
    if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_width
        $error("ahb_sram_slave: DATA_WIDTH must be 32 or 64");
    end
    if (WAIT_STATES > 15) begin : g_bad_wait
        $error("ahb_sram_slave: WAIT_STATES must be 0..15");
    end

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StData,
        StErr1,
        StErr2
    } state_e;

    // Data-phase context captured from the accepted address phase.
    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [NumBytes-1:0]   mask_q, mask_d;
    logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;

    // Storage; deliberately not reset.
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // Address-phase decode.
    logic                  can_accept;
    logic                  accept;
    logic                  req_err;
    logic [31:0]           size_bytes;
    logic [31:0]           word_full;
    logic [IdxW-1:0]       req_idx;
    logic [LaneW-1:0]      req_lane;
    logic [NumBytes-1:0]   req_mask;

    // Write path and forwarded read word.
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] rd_word;

    logic unused_inputs;
    assign unused_inputs = ^{HBURST, HTRANS[0]};

    // Decode the address phase presented on the bus: legality, word index, lane mask.
    always_comb begin
        size_bytes = 32'd1 << HSIZE;
        word_full  = 32'(HADDR) >> LaneW;
        req_idx    = IdxW'(word_full);
        req_lane   = HADDR[LaneW-1:0];
        req_err    = 1'b0;
        if (32'(HSIZE) > LaneW) begin
            req_err = 1'b1;
        end
        if ((32'(HADDR) & (size_bytes - 32'd1)) != 32'd0) begin
            req_err = 1'b1;
        end
        if (word_full >= MEM_DEPTH) begin
            req_err = 1'b1;
        end
        // Oversized HSIZE only occurs with req_err set, so wrap here is harmless.
        req_mask = NumBytes'(((32'd1 << size_bytes) - 32'd1) << req_lane);
    end

    // A new address phase may only be taken while this slave is driving HREADYOUT high.
    always_comb begin
        can_accept = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);
        accept     = HSEL && HTRANS[1] && HREADY && can_accept;
    end

    // Merge write lanes into the stored word; forward it to a read of the same word.
    always_comb begin
        mem_we  = (state_q == StData) && write_q;
        wr_word = mem_q[idx_q];
        for (int b = 0; b < NumBytes; b++) begin
            if (mask_q[b]) begin
                wr_word[8*b +: 8] = HWDATA[8*b +: 8];
            end
        end
        rd_word = mem_q[req_idx];
        if (mem_we && (req_idx == idx_q)) begin
            rd_word = wr_word;
        end
    end

    // FSM next state, captured data-phase context, and bus outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        write_d   = write_q;
        idx_d     = idx_q;
        mask_d    = mask_q;
        hrdata_d  = hrdata_q;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;

        unique case (state_q)
            StIdle: begin
                state_d = StIdle;
            end
            StWait: begin
                HREADYOUT = 1'b0;
                if (cnt_q == 4'd0) begin
                    state_d = StData;
                    if (!write_q) begin
                        hrdata_d = mem_q[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StData: begin
                state_d = StIdle;
            end
            StErr1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_d   = StErr2;
            end
            StErr2: begin
                HRESP   = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Pipelined accept overrides the default completion path.
        if (accept) begin
            write_d = HWRITE;
            idx_d   = req_idx;
            mask_d  = req_mask;
            if (req_err) begin
                state_d = StErr1;
                if (!HWRITE) begin
                    hrdata_d = '0;
                end
            end else if (WAIT_STATES > 0) begin
                state_d = StWait;
                cnt_d   = 4'(WAIT_STATES - 1);
            end else begin
                state_d = StData;
                if (!HWRITE) begin
                    hrdata_d = rd_word;
                end
            end
        end
    end

    assign HRDATA = hrdata_q;

    // Control state register with synchronous reset.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            write_q  <= 1'b0;
            idx_q    <= '0;
            mask_q   <= '0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            idx_q    <= idx_d;
            mask_q   <= mask_d;
            hrdata_q <= hrdata_d;
        end
    end

    // SRAM write on the completing edge; reset abandons an in-flight write.
    always_ff @(posedge ACLK) begin
        if (mem_we && !ARESET) begin
            mem_q[idx_q] <= wr_word;
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Randomised scoreboard bench for ahb_sram_slave: zero-wait instance driven by a
// pipelined master and checked by a monitor; a two-wait-state instance gets
// directed wait-state and mid-transfer reset checks.
module tb_ahb_sram_slave;

    localparam int DEPTH = 64;

    logic ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_vec = 0;
    int n_bad = 0;

    // Zero-wait instance
    logic        rst0, hsel, hwrite, hreadyout, hresp;
    logic [7:0]  haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [31:0] hwdata, hrdata;

    ahb_sram_slave #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .MEM_DEPTH  (DEPTH),
        .WAIT_STATES(0)
    ) u_dut0 (
        .ACLK     (ACLK),
        .ARESET   (rst0),
        .HSEL     (hsel),
        .HADDR    (haddr),
        .HTRANS   (htrans),
        .HWRITE   (hwrite),
        .HSIZE    (hsize),
        .HBURST   (hburst),
        .HWDATA   (hwdata),
        .HREADY   (hreadyout),
        .HREADYOUT(hreadyout),
        .HRESP    (hresp),
        .HRDATA   (hrdata)
    );

    // Two-wait-state instance
    logic        rst2, w2_sel, w2_write, w2_ready, w2_resp;
    logic [7:0]  w2_addr;
    logic [1:0]  w2_trans;
    logic [2:0]  w2_size, w2_burst;
    logic [31:0] w2_wdata, w2_rdata;

    ahb_sram_slave #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .MEM_DEPTH  (DEPTH),
        .WAIT_STATES(2)
    ) u_dut2 (
        .ACLK     (ACLK),
        .ARESET   (rst2),
        .HSEL     (w2_sel),
        .HADDR    (w2_addr),
        .HTRANS   (w2_trans),
        .HWRITE   (w2_write),
        .HSIZE    (w2_size),
        .HBURST   (w2_burst),
        .HWDATA   (w2_wdata),
        .HREADY   (w2_ready),
        .HREADYOUT(w2_ready),
        .HRESP    (w2_resp),
        .HRDATA   (w2_rdata)
    );

    typedef struct {
        logic        rd;
        logic        err;
        logic [31:0] data;
        int          stalls;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] model [DEPTH];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Wait (bounded) for a negedge at which the zero-wait slave is ready.
    task automatic wait_ready();
        int n = 0;
        @(negedge ACLK);
        while (!hreadyout && n < 50) begin
            n++;
            @(negedge ACLK);
        end
        if (!hreadyout) begin
            n_vec++;
            n_bad++;
            $display("FAIL ready_timeout: HREADYOUT got 0, expected 1");
        end
    endtask

    // Model the beat from the bus rules, queue the expectation, then drive it.
    task automatic beat(input logic wr, input logic [7:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input logic seq, input string nm);
        exp_t e;
        int   ai, nb, w, lo;
        logic bad;
        ai  = int'(a);
        nb  = 1 << sz;
        w   = ai / 4;
        bad = (sz > 3'd2) || ((ai % nb) != 0) || (w >= DEPTH);
        e.rd     = !wr;
        e.err    = bad;
        e.stalls = bad ? 1 : 0;
        e.name   = nm;
        e.data   = 32'h0;
        if (!bad) begin
            if (wr) begin
                for (int k = 0; k < nb; k++) begin
                    lo = 8 * ((ai % 4) + k);
                    model[w][lo +: 8] = wd[lo +: 8];
                end
            end else begin
                e.data = model[w];
            end
        end
        sb.push_back(e);
        hsel   = 1'b1;
        htrans = seq ? 2'b11 : 2'b10;
        haddr  = a;
        hwrite = wr;
        hsize  = sz;
        hburst = seq ? 3'b001 : 3'b000;
        wait_ready();
        @(posedge ACLK);
        #1;
        hwdata = wd;
    endtask

    // Non-transfer cycle: kind 0 deselected, 1 BUSY while selected, 2 NONSEQ while deselected.
    task automatic gap(input int kind);
        hsel   = (kind == 1);
        htrans = (kind == 0) ? 2'b00 : ((kind == 1) ? 2'b01 : 2'b10);
        wait_ready();
        @(posedge ACLK);
        #1;
    endtask

    // Monitor: follows data phases of the zero-wait slave and scores them.
    logic in_data = 1'b0;
    int   stalls  = 0;
    always @(negedge ACLK) begin
        if (rst0) begin
            in_data = 1'b0;
            stalls  = 0;
        end else begin
            if (in_data) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL sb_empty: got a data phase, expected none");
                end else if (!hreadyout) begin
                    stalls++;
                    check({sb[0].name, "_resp_stall"}, 32'(hresp), 32'(sb[0].err));
                end else begin
                    mon_e = sb.pop_front();
                    check({mon_e.name, "_resp"}, 32'(hresp), 32'(mon_e.err));
                    check({mon_e.name, "_stalls"}, 32'(stalls), 32'(mon_e.stalls));
                    if (mon_e.rd) begin
                        check({mon_e.name, "_data"}, hrdata, mon_e.data);
                    end
                    stalls = 0;
                end
            end
            if (hreadyout) begin
                in_data = hsel && htrans[1];
            end
        end
    end

    // Directed single transfer on the two-wait-state instance.
    task automatic w2_xfer(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                           output int lows, output logic [31:0] rd);
        w2_sel   = 1'b1;
        w2_trans = 2'b10;
        w2_write = wr;
        w2_addr  = a;
        w2_size  = 3'd2;
        @(posedge ACLK);
        #1;
        w2_sel   = 1'b0;
        w2_trans = 2'b00;
        w2_wdata = wd;
        lows     = 0;
        @(negedge ACLK);
        while (!w2_ready && lows < 20) begin
            lows++;
            @(negedge ACLK);
        end
        rd = w2_rdata;
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation got no finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lows;
        logic [31:0] rd;
        logic [7:0]  a;
        logic [2:0]  sz;

        rst0 = 1'b1; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = '0;
        hsize = 3'd2; hburst = '0; hwdata = '0;
        rst2 = 1'b1; w2_sel = 1'b0; w2_trans = 2'b00; w2_write = 1'b0; w2_addr = '0;
        w2_size = 3'd2; w2_burst = '0; w2_wdata = '0;
        repeat (5) @(posedge ACLK);
        #1;
        rst0 = 1'b0;
        rst2 = 1'b0;
        @(negedge ACLK);
        check("reset_hreadyout", 32'(hreadyout), 32'd1);
        check("reset_hresp", 32'(hresp), 32'd0);
        check("reset_hrdata", hrdata, 32'h0);
        @(posedge ACLK);
        #1;

        // Basic write then read of word 0.
        beat(1'b1, 8'h00, 3'd2, 32'h0000_0003, 1'b0, "t1_wr");
        beat(1'b0, 8'h00, 3'd2, 32'h0, 1'b0, "t1_rd");
        gap(0);
        gap(0);
        check("hrdata_hold", hrdata, 32'h0000_0003);

        // Define every word, then a 32-beat INCR burst and readback.
        for (int i = 0; i < DEPTH; i++) begin
            beat(1'b1, 8'(4 * i), 3'd2, $urandom, i != 0, "fill");
        end
        for (int i = 0; i < 32; i++) begin
            beat(1'b1, 8'(8'h40 + 4 * i), 3'd2, 32'h6434_3962 + 32'(i), i != 0, "t2_wr");
        end
        for (int i = 0; i < 32; i++) begin
            beat(1'b0, 8'(8'h40 + 4 * i), 3'd2, 32'h0, i != 0, "t2_rd");
        end
        gap(0);

        // Byte-lane write.
        beat(1'b1, 8'h08, 3'd2, 32'h1122_3344, 1'b0, "t3_wr");
        beat(1'b1, 8'h09, 3'd0, 32'h0000_AA00, 1'b0, "t3_byte");
        beat(1'b0, 8'h08, 3'd2, 32'h0, 1'b0, "t3_rd");
        gap(0);

        // Boundary index, misaligned write, oversize read.
        beat(1'b0, 8'hFC, 3'd2, 32'h0, 1'b0, "t5_top");
        beat(1'b1, 8'h02, 3'd2, 32'hFFFF_FFFF, 1'b0, "t5_misal");
        beat(1'b0, 8'h00, 3'd2, 32'h0, 1'b0, "t5_unchg");
        beat(1'b0, 8'h00, 3'd3, 32'h0, 1'b0, "t5_errrd");
        gap(0);

        // Read directly after write to the same word.
        beat(1'b1, 8'h10, 3'd2, 32'hDEAD_BEEF, 1'b0, "t6_wr");
        beat(1'b0, 8'h10, 3'd2, 32'h0, 1'b0, "t6_rd");
        gap(0);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            sz = 3'($urandom_range(0, 3));
            a  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                a = a & ~8'((1 << sz) - 1);
            end
            beat(1'($urandom_range(0, 1)), a, sz, $urandom, 1'($urandom_range(0, 1)), "rnd");
            if ($urandom_range(0, 7) == 0) begin
                gap($urandom_range(0, 2));
            end
        end
        gap(0);
        gap(0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        // Wait-state instance.
        w2_xfer(1'b1, 8'h20, 32'hCAFE_F00D, lows, rd);
        check("w2_wr_lows", 32'(lows), 32'd2);
        w2_xfer(1'b0, 8'h20, 32'h0, lows, rd);
        check("w2_rd_lows", 32'(lows), 32'd2);
        check("w2_rd_data", rd, 32'hCAFE_F00D);

        // Reset during the second wait cycle of a write abandons it.
        w2_sel   = 1'b1;
        w2_trans = 2'b10;
        w2_write = 1'b1;
        w2_addr  = 8'h20;
        @(posedge ACLK);
        #1;
        w2_sel   = 1'b0;
        w2_trans = 2'b00;
        w2_wdata = 32'h1234_5678;
        @(posedge ACLK);
        @(negedge ACLK);
        check("w2_in_wait", 32'(w2_ready), 32'd0);
        rst2 = 1'b1;
        @(posedge ACLK);
        #1;
        rst2 = 1'b0;
        @(negedge ACLK);
        check("w2_post_rst_ready", 32'(w2_ready), 32'd1);
        check("w2_post_rst_resp", 32'(w2_resp), 32'd0);
        check("w2_post_rst_hrdata", w2_rdata, 32'h0);
        repeat (3) @(posedge ACLK);
        #1;
        w2_xfer(1'b0, 8'h20, 32'h0, lows, rd);
        check("w2_after_rst_lows", 32'(lows), 32'd2);
        check("w2_no_write", rd, 32'hCAFE_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
